// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared constants and helpers for the async_fifo block.
//   DEF_DEPTH / DEF_WIDTH / DEF_PTR_WIDTH : default geometry
//   flags_t                               : packed {full, empty} pair
//   calc_flags()                          : full/empty from two wrap-bit pointers
// -----------------------------------------------------------------------------
package async_fifo_pkg;

    localparam int DEF_DEPTH     = 16;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_PTR_WIDTH = 4;

    // Pointers are passed zero-extended to this width so one function serves
    // any PTR_WIDTH up to 30.
    localparam int MAX_PTR_W = 32;

    typedef struct packed {
        logic full;
        logic empty;
    } flags_t;

    // Pointers carry one extra wrap bit at index pw. Equal pointers mean empty.
    // Equal low bits with differing wrap bits mean the writer is one lap ahead.
    function automatic flags_t calc_flags(
        input logic [MAX_PTR_W-1:0] wr,
        input logic [MAX_PTR_W-1:0] rd,
        input int                   pw
    );
        logic [MAX_PTR_W-1:0] low_mask;
        flags_t               f;
        low_mask = (MAX_PTR_W'(1) << pw) - MAX_PTR_W'(1);
        f.empty  = (wr == rd);
        f.full   = (wr[pw] != rd[pw]) && ((wr & low_mask) == (rd & low_mask));
        return f;
    endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// -----------------------------------------------------------------------------
// async_fifo_mem
// DEPTH x WIDTH storage with a synchronous write port and a registered read
// port. Only the read data register is reset; the array keeps its contents.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset (read reg only)
//   i_we, i_waddr, i_wdata: write port, written on the rising edge when i_we=1
//   i_re, i_raddr, o_rdata: read port, o_rdata loads mem[i_raddr] when i_re=1
//                           and holds otherwise
// -----------------------------------------------------------------------------
module async_fifo_mem
    import async_fifo_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int PTR_WIDTH = DEF_PTR_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_we,
    input  logic [PTR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]     i_wdata,
    input  logic                 i_re,
    input  logic [PTR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]     o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/async_fifo.sv
// -----------------------------------------------------------------------------
// async_fifo
// Single-clock FIFO with registered read data and a one-cycle error pulse for
// dropped requests. The name is kept for existing instantiations.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   wr_en_i, wdata_i  : write request and data
//   rd_en_i, rdata_o  : read request, registered read data (1-cycle latency)
//   full_o, empty_o   : occupancy flags from the registered pointers
//   error_o           : 1 for one cycle after an overflow or underflow attempt
//
// Request semantics: wr_en_i / rd_en_i are single-cycle requests with no
// back-pressure wait. A write is taken at the edge only if full_o is low, a read
// only if empty_o is low, both judged on the flags seen before that edge. A
// request made against the blocking flag is dropped, not retried, and raises
// error_o for the next cycle.
// -----------------------------------------------------------------------------
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int PTR_WIDTH = DEF_PTR_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             error_o
);

    localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

    logic [PTR_WIDTH:0] r_wr_ptr;
    logic [PTR_WIDTH:0] r_rd_ptr;
    logic               r_error;
    flags_t             w_flags;
    logic               w_wr_accept;
    logic               w_rd_accept;

    assign w_flags     = calc_flags(MAX_PTR_W'(r_wr_ptr), MAX_PTR_W'(r_rd_ptr), PTR_WIDTH);
    assign w_wr_accept = wr_en_i & ~w_flags.full;
    assign w_rd_accept = rd_en_i & ~w_flags.empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_error <= (wr_en_i & w_flags.full) | (rd_en_i & w_flags.empty);
        end
    end

    // Write enable is gated by rst_i so a request in the reset cycle cannot
    // leave a stray word behind the cleared pointers.
    async_fifo_mem #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_we    (w_wr_accept & ~rst_i),
        .i_waddr (r_wr_ptr[PTR_WIDTH-1:0]),
        .i_wdata (wdata_i),
        .i_re    (w_rd_accept),
        .i_raddr (r_rd_ptr[PTR_WIDTH-1:0]),
        .o_rdata (rdata_o)
    );

    assign full_o  = w_flags.full;
    assign empty_o = w_flags.empty;
    assign error_o = r_error;

endmodule

// File: tb/tb_async_fifo.sv
module tb_async_fifo;

    localparam int DEPTH     = 16;
    localparam int WIDTH     = 8;
    localparam int PTR_WIDTH = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             wr_en_i;
    logic [WIDTH-1:0] wdata_i;
    logic             full_o;
    logic             rd_en_i;
    logic [WIDTH-1:0] rdata_o;
    logic             empty_o;
    logic             error_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] last_rdata;

    typedef struct {
        logic             wr;
        logic             rd;
        logic [WIDTH-1:0] wdata;
        logic             exp_empty;
        logic             exp_full;
        logic             exp_err;
        logic [WIDTH-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    async_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en_i (wr_en_i),
        .wdata_i (wdata_i),
        .full_o  (full_o),
        .rd_en_i (rd_en_i),
        .rdata_o (rdata_o),
        .empty_o (empty_o),
        .error_o (error_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        rst_i   = 1'b1;
        wr_en_i = 1'b1;
        rd_en_i = 1'b1;
        wdata_i = 8'h5A;
        @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        model_q.delete();
        exp_q.delete();
        last_rdata = '0;
        check("reset empty_o", 32'(empty_o), 32'd1);
        check("reset full_o",  32'(full_o),  32'd0);
        check("reset rdata_o", 32'(rdata_o), 32'd0);
        check("reset error_o", 32'(error_o), 32'd0);
    endtask

    // One cycle of traffic checked against the reference queue model.
    task automatic op(input logic w, input logic r, input string tag);
        logic [WIDTH-1:0] d;
        logic was_full, was_empty, exp_err, rd_ok;
        d         = WIDTH'($urandom_range(0, 255));
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        exp_err   = (w && was_full) || (r && was_empty);
        rd_ok     = r && !was_empty;
        if (rd_ok) exp_q.push_back(model_q.pop_front());
        if (w && !was_full) model_q.push_back(d);
        wr_en_i = w;
        rd_en_i = r;
        wdata_i = d;
        @(posedge clk_i);
        #1;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        if (rd_ok) last_rdata = exp_q.pop_front();
        check({tag, " error_o"}, 32'(error_o), 32'(exp_err));
        check({tag, " empty_o"}, 32'(empty_o), 32'(model_q.size() == 0));
        check({tag, " full_o"},  32'(full_o),  32'(model_q.size() == DEPTH));
        check({tag, " rdata_o"}, 32'(rdata_o), 32'(last_rdata));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic w, r;
        int   wcnt, rcnt, wgap, rgap, cyc;

        rst_i      = 1'b1;
        wr_en_i    = 1'b0;
        rd_en_i    = 1'b0;
        wdata_i    = '0;
        last_rdata = '0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("initial empty_o", 32'(empty_o), 32'd1);
        check("initial full_o",  32'(full_o),  32'd0);
        check("initial rdata_o", 32'(rdata_o), 32'd0);
        check("initial error_o", 32'(error_o), 32'd0);

        // Hand-derived short sequence starting from an empty FIFO.
        vecs[0] = '{1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 8'hB2, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA1};
        vecs[3] = '{1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 8'hB2};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'hC3};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'hC3};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hC3};
        vecs[7] = '{1'b1, 1'b1, 8'hD4, 1'b0, 1'b0, 1'b1, 8'hC3};
        vecs[8] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'hD4};

        for (int i = 0; i < 9; i++) begin
            wr_en_i = vecs[i].wr;
            rd_en_i = vecs[i].rd;
            wdata_i = vecs[i].wdata;
            @(posedge clk_i);
            #1;
            wr_en_i = 1'b0;
            rd_en_i = 1'b0;
            check($sformatf("vec%0d empty_o", i), 32'(empty_o), 32'(vecs[i].exp_empty));
            check($sformatf("vec%0d full_o", i),  32'(full_o),  32'(vecs[i].exp_full));
            check($sformatf("vec%0d error_o", i), 32'(error_o), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d rdata_o", i), 32'(rdata_o), 32'(vecs[i].exp_rdata));
        end

        // Fill then drain.
        do_reset();
        for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, "fill");
        check("fill full_o", 32'(full_o), 32'd1);
        for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, "drain");
        check("drain empty_o", 32'(empty_o), 32'd1);

        // Overflow: 17 writes, error pulse, then drain only 16.
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) op(1'b1, 1'b0, "ovf");
        check("ovf pulse", 32'(error_o), 32'd1);
        op(1'b0, 1'b0, "ovf idle");
        for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, "ovf drain");

        // Underflow: fill, 17 reads.
        do_reset();
        for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, "udf fill");
        for (int i = 0; i < DEPTH + 1; i++) op(1'b0, 1'b1, "udf");
        check("udf pulse", 32'(error_o), 32'd1);
        op(1'b0, 1'b0, "udf idle");

        // Simultaneous read/write: empty, half-full, full.
        do_reset();
        op(1'b1, 1'b1, "simul empty");
        for (int i = 0; i < 7; i++) op(1'b1, 1'b0, "half fill");
        for (int i = 0; i < 4; i++) op(1'b1, 1'b1, "simul half");
        for (int i = 0; i < 8; i++) op(1'b1, 1'b0, "top fill");
        check("simul pre-full", 32'(full_o), 32'd1);
        op(1'b1, 1'b1, "simul full");
        op(1'b0, 1'b0, "simul idle");
        while (model_q.size() > 0) op(1'b0, 1'b1, "simul drain");

        // Long random traffic across many pointer wraps.
        do_reset();
        wcnt = 0; rcnt = 0; cyc = 0;
        wgap = $urandom_range(1, 13);
        rgap = $urandom_range(1, 13);
        while ((wcnt < 500 || rcnt < 500) && cyc < 20000) begin
            w = (wcnt < 500) && (wgap == 0) && (model_q.size() < DEPTH);
            r = (rcnt < 500) && (rgap == 0) && (model_q.size() > 0);
            op(w, r, "wrap");
            if (w) begin wcnt++; wgap = $urandom_range(1, 13); end
            else if (wgap > 0) wgap--;
            if (r) begin rcnt++; rgap = $urandom_range(1, 13); end
            else if (rgap > 0) rgap--;
            cyc++;
        end
        check("wrap completed in budget", 32'(cyc < 20000), 32'd1);

        // Reset in the middle of traffic discards everything.
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, "pre-rst");
        op(1'b0, 1'b1, "pre-rst read");
        do_reset();
        op(1'b0, 1'b1, "post-rst read");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
